// File: rtl/rvc_asap_dmem_if.sv
`default_nettype none
// ============================================================================
// Module      : rvc_asap_dmem_if
// Description : D_MEM bus between the rvc_asap core (master) and its data
//               memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface rvc_asap_dmem_if;
    logic [31:0] address;
    logic [31:0] wr_data;
    logic [3:0]  byte_en;
    logic        wr_en;
    logic        rd_en;
    logic        sign_ext;
    logic [31:0] rd_data;

    modport master (
        output address, wr_data, byte_en, wr_en, rd_en, sign_ext,
        input  rd_data
    );

    modport slave (
        input  address, wr_data, byte_en, wr_en, rd_en, sign_ext,
        output rd_data
    );
endinterface
`default_nettype wire

// File: rtl/rvc_asap_dmem.sv
`default_nettype none
// ============================================================================
// Module      : rvc_asap_dmem
// Description : Zero-latency data memory for rvc_asap with lane alignment,
//               load extension and sticky misalign/range error status.
//               Optional MMIO output register: define RVC_DMEM_MMIO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rvc_asap_dmem #(
    parameter int          DMEM_ADRS_WIDTH = 12,
    parameter logic [31:0] DMEM_BASE       = 32'h0000_2000
`ifdef RVC_DMEM_MMIO_EN
    ,
    parameter logic [31:0] MMIO_ADRS       = 32'h0000_3F00
`endif
) (
    input  wire logic        clk,
    input  wire logic        rst,
    rvc_asap_dmem_if.slave   bus,
    output logic             misalign_err_o,
    output logic             range_err_o,
    output logic [31:0]      err_addr_o,
    output logic [15:0]      store_cnt_o
`ifdef RVC_DMEM_MMIO_EN
    ,
    output logic [31:0]      mmio_out_o
`endif
);

    localparam int c_WORDS = 2 ** (DMEM_ADRS_WIDTH - 2);

    logic [31:0] mem_q [0:c_WORDS-1];

    logic        misalign_q, misalign_d;
    logic        range_q, range_d;
    logic [31:0] err_addr_q, err_addr_d;
    logic [15:0] store_cnt_q, store_cnt_d;
    logic [31:0] mmio_q, mmio_d;

    logic [1:0]                 w_off;
    logic [DMEM_ADRS_WIDTH-3:0] w_idx;
    logic                       w_hit;
    logic                       w_mmio_sel;
    logic                       w_mis;
    logic                       w_oor;
    logic                       w_access;
    logic                       w_err;
    logic                       w_store;
    logic                       w_mem_we;
    logic [3:0]                 w_lane;
    logic [31:0]                w_wdata_sh;
    logic [31:0]                w_rd_word;
    logic [31:0]                w_rd_sh;
    logic [31:0]                w_rd_data;

    assign w_off = bus.address[1:0];
    assign w_idx = bus.address[DMEM_ADRS_WIDTH-1:2];
    assign w_hit = (bus.address[31:DMEM_ADRS_WIDTH] == DMEM_BASE[31:DMEM_ADRS_WIDTH]);

`ifdef RVC_DMEM_MMIO_EN
    assign w_mmio_sel = (bus.address[31:2] == MMIO_ADRS[31:2]);
`else
    assign w_mmio_sel = 1'b0;
`endif

    // Only byte, aligned half and aligned word are legal; the MMIO register is word-only.
    always_comb begin
        w_mis = 1'b0;
        case (bus.byte_en)
            4'b0000: w_mis = 1'b0;
            4'b0001: w_mis = 1'b0;
            4'b0011: w_mis = w_off[0];
            4'b1111: w_mis = (w_off != 2'b00);
            default: w_mis = 1'b1;
        endcase
        if (w_mmio_sel && (bus.byte_en != 4'b0000) && (bus.byte_en != 4'b1111)) begin
            w_mis = 1'b1;
        end
    end

    assign w_oor      = !w_hit && !w_mmio_sel;
    assign w_access   = (bus.rd_en || bus.wr_en) && (bus.byte_en != 4'b0000);
    assign w_err      = w_access && (w_mis || w_oor);
    assign w_store    = bus.wr_en && (bus.byte_en != 4'b0000) && !w_err;
    assign w_mem_we   = w_store && w_hit && !w_mmio_sel;
    assign w_lane     = bus.byte_en << w_off;
    assign w_wdata_sh = bus.wr_data << {w_off, 3'b000};

    // Array is deliberately left out of reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_lane[i]) begin
                    mem_q[w_idx][8*i +: 8] <= w_wdata_sh[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        w_rd_word = mem_q[w_idx];
        if (w_mmio_sel) begin
            w_rd_word = mmio_q;
        end
        w_rd_sh   = w_rd_word >> {w_off, 3'b000};
        w_rd_data = 32'h0;
        if (bus.rd_en && !w_err) begin
            case (bus.byte_en)
                4'b0001: w_rd_data = {{24{bus.sign_ext & w_rd_sh[7]}},  w_rd_sh[7:0]};
                4'b0011: w_rd_data = {{16{bus.sign_ext & w_rd_sh[15]}}, w_rd_sh[15:0]};
                4'b1111: w_rd_data = w_rd_sh;
                default: w_rd_data = 32'h0;
            endcase
        end
    end

    assign bus.rd_data = w_rd_data;

    always_comb begin
        misalign_d  = misalign_q;
        range_d     = range_q;
        err_addr_d  = err_addr_q;
        store_cnt_d = store_cnt_q;
        mmio_d      = mmio_q;
        if (w_err) begin
            if (w_mis) begin
                misalign_d = 1'b1;
            end else begin
                range_d = 1'b1;
            end
            // First error since reset wins.
            if (!misalign_q && !range_q) begin
                err_addr_d = bus.address;
            end
        end
        if (w_store) begin
            if (store_cnt_q != 16'hFFFF) begin
                store_cnt_d = store_cnt_q + 16'd1;
            end
            if (w_mmio_sel) begin
                mmio_d = bus.wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q  <= 1'b0;
            range_q     <= 1'b0;
            err_addr_q  <= 32'h0;
            store_cnt_q <= 16'h0;
            mmio_q      <= 32'h0;
        end else begin
            misalign_q  <= misalign_d;
            range_q     <= range_d;
            err_addr_q  <= err_addr_d;
            store_cnt_q <= store_cnt_d;
            mmio_q      <= mmio_d;
        end
    end

    assign misalign_err_o = misalign_q;
    assign range_err_o    = range_q;
    assign err_addr_o     = err_addr_q;
    assign store_cnt_o    = store_cnt_q;

`ifdef RVC_DMEM_MMIO_EN
    assign mmio_out_o = mmio_q;
`else
    logic w_unused;
    assign w_unused = ^mmio_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rvc_asap_dmem.sv
`default_nettype none
// ============================================================================
// Module      : tb_rvc_asap_dmem
// Description : Directed self-checking bench for rvc_asap_dmem.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rvc_asap_dmem;

    logic        clk;
    logic        rst;
    logic        misalign_err;
    logic        range_err;
    logic [31:0] err_addr;
    logic [15:0] store_cnt;
`ifdef RVC_DMEM_MMIO_EN
    logic [31:0] mmio_out;
`endif

    int n_checks;
    int n_fail;

    rvc_asap_dmem_if bus ();

    rvc_asap_dmem u_dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .misalign_err_o (misalign_err),
        .range_err_o    (range_err),
        .err_addr_o     (err_addr),
        .store_cnt_o    (store_cnt)
`ifdef RVC_DMEM_MMIO_EN
        ,
        .mmio_out_o     (mmio_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic wr, input logic rd,
                         input logic sx);
        bus.address  = addr;
        bus.wr_data  = wdata;
        bus.byte_en  = be;
        bus.wr_en    = wr;
        bus.rd_en    = rd;
        bus.sign_ext = sx;
        #1;
    endtask

    task automatic idle();
        drive(32'h0, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        drive(addr, wdata, be, 1'b1, 1'b0, 1'b0);
        step();
        idle();
    endtask

    task automatic load_chk(input string tag, input logic [31:0] addr, input logic [3:0] be,
                            input logic sx, input logic [31:0] exp);
        drive(addr, 32'h0, be, 1'b0, 1'b1, sx);
        chk(tag, bus.rd_data, exp);
        idle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        idle();
        step();
        step();
        rst = 1'b0;
        chk("rst_misalign", {31'h0, misalign_err}, 32'h0);
        chk("rst_range",    {31'h0, range_err},    32'h0);
        chk("rst_erraddr",  err_addr,              32'h0);
        chk("rst_cnt",      {16'h0, store_cnt},    32'h0);
        chk("idle_rddata",  bus.rd_data,           32'h0);

        // Word store/load
        store(32'h0000_2004, 32'hDEAD_BEEF, 4'b1111);
        chk("cnt_after_word", {16'h0, store_cnt}, 32'd1);
        load_chk("word_load", 32'h0000_2004, 4'b1111, 1'b0, 32'hDEAD_BEEF);
        drive(32'h0000_2004, 32'h0, 4'b1111, 1'b0, 1'b0, 1'b0);
        chk("rd_en_low", bus.rd_data, 32'h0);
        drive(32'h0000_2004, 32'h0, 4'b0000, 1'b0, 1'b1, 1'b0);
        chk("be_zero", bus.rd_data, 32'h0);
        idle();

        // Byte lanes and sign extension
        store(32'h0000_2008, 32'h0000_0000, 4'b1111);
        store(32'h0000_2009, 32'h0000_0080, 4'b0001);
        load_chk("byte_signed",   32'h0000_2009, 4'b0001, 1'b1, 32'hFFFF_FF80);
        load_chk("byte_unsigned", 32'h0000_2009, 4'b0001, 1'b0, 32'h0000_0080);
        load_chk("byte_word",     32'h0000_2008, 4'b1111, 1'b0, 32'h0000_8000);

        // Halfword into upper half of a word with a known lower half
        store(32'h0000_200C, 32'h0000_7777, 4'b1111);
        store(32'h0000_200E, 32'h1234_ABCD, 4'b0011);
        load_chk("half_signed",   32'h0000_200E, 4'b0011, 1'b1, 32'hFFFF_ABCD);
        load_chk("half_unsigned", 32'h0000_200E, 4'b0011, 1'b0, 32'h0000_ABCD);
        load_chk("half_word",     32'h0000_200C, 4'b1111, 1'b0, 32'hABCD_7777);
        store(32'h0000_2000, 32'h0102_0304, 4'b1111);
        chk("cnt_before_err", {16'h0, store_cnt}, 32'd6);

        // Misaligned word store is suppressed
        store(32'h0000_2002, 32'hCAFE_F00D, 4'b1111);
        chk("mis_flag",    {31'h0, misalign_err}, 32'h1);
        chk("mis_range",   {31'h0, range_err},    32'h0);
        chk("mis_erraddr", err_addr,              32'h0000_2002);
        chk("mis_cnt",     {16'h0, store_cnt},    32'd6);
        load_chk("mis_nowrite", 32'h0000_2000, 4'b1111, 1'b0, 32'h0102_0304);
        load_chk("mis_load0",   32'h0000_2001, 4'b0011, 1'b1, 32'h0);
        load_chk("illegal_be",  32'h0000_2000, 4'b0101, 1'b0, 32'h0);

        // Out-of-range store: flag sets, first error address kept
        store(32'h0000_0100, 32'h5555_5555, 4'b1111);
        chk("oor_range",   {31'h0, range_err}, 32'h1);
        chk("oor_erraddr", err_addr,           32'h0000_2002);
        chk("oor_cnt",     {16'h0, store_cnt}, 32'd6);

        // Reset clears status, memory survives
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_misalign", {31'h0, misalign_err}, 32'h0);
        chk("rst2_range",    {31'h0, range_err},    32'h0);
        chk("rst2_erraddr",  err_addr,              32'h0);
        chk("rst2_cnt",      {16'h0, store_cnt},    32'h0);
        load_chk("mem_retained", 32'h0000_2004, 4'b1111, 1'b0, 32'hDEAD_BEEF);

        // Same-cycle read and write returns old data
        store(32'h0000_2010, 32'h1111_1111, 4'b1111);
        drive(32'h0000_2010, 32'h2222_2222, 4'b1111, 1'b1, 1'b1, 1'b0);
        chk("rw_old", bus.rd_data, 32'h1111_1111);
        step();
        load_chk("rw_new", 32'h0000_2010, 4'b1111, 1'b0, 32'h2222_2222);
        chk("rw_cnt", {16'h0, store_cnt}, 32'd2);

        // Read-only out-of-range access records the error
        drive(32'h0000_4000, 32'h0, 4'b1111, 1'b0, 1'b1, 1'b0);
        chk("oor_load0", bus.rd_data, 32'h0);
        step();
        idle();
        chk("oorld_range",   {31'h0, range_err},    32'h1);
        chk("oorld_mis",     {31'h0, misalign_err}, 32'h0);
        chk("oorld_erraddr", err_addr,              32'h0000_4000);

        // Store during reset still commits to the array
        rst = 1'b1;
        drive(32'h0000_2014, 32'h3333_3333, 4'b1111, 1'b1, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        idle();
        chk("rststore_cnt", {16'h0, store_cnt}, 32'h0);
        chk("rststore_rng", {31'h0, range_err}, 32'h0);
        load_chk("rststore_mem", 32'h0000_2014, 4'b1111, 1'b0, 32'h3333_3333);

        // MMIO address
        store(32'h0000_3F00, 32'hA5A5_A5A5, 4'b1111);
`ifdef RVC_DMEM_MMIO_EN
        chk("mmio_out",   mmio_out,              32'hA5A5_A5A5);
        chk("mmio_range", {31'h0, range_err},    32'h0);
        chk("mmio_cnt",   {16'h0, store_cnt},    32'd1);
        load_chk("mmio_load", 32'h0000_3F00, 4'b1111, 1'b0, 32'hA5A5_A5A5);
        store(32'h0000_3F00, 32'h0000_00FF, 4'b0001);
        chk("mmio_sub_mis", {31'h0, misalign_err}, 32'h1);
        chk("mmio_sub_out", mmio_out,              32'hA5A5_A5A5);
`else
        chk("nommio_range",   {31'h0, range_err}, 32'h1);
        chk("nommio_erraddr", err_addr,           32'h0000_3F00);
        chk("nommio_cnt",     {16'h0, store_cnt}, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
